ixu_ex_wb_pipe: RTL and testbench



---
 rtl/ixu_pkg.sv | 22 ++
 rtl/ixu_ex_wb_pipe_if.sv | 28 ++
 rtl/ixu_skid_buf.sv | 76 +++++++
 rtl/ixu_ex_wb_pipe.sv | 86 ++++++++
 tb/tb_ixu_ex_wb_pipe.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ixu_pkg.sv
// Shared types for the integer-execution writeback path: lane layout,
// skid-buffer occupancy states and the hard-wired zero register.
package ixu_pkg;

   localparam int IXU_XLEN = 32;
   localparam int IXU_RA_W = 5;
   localparam int X0_ADDR  = 0;

   // Default-width lane layout; the pipe declares the same field order at its own widths.
   typedef struct packed {
      logic                is_nop;
      logic [IXU_RA_W-1:0] rd;
      logic [IXU_XLEN-1:0] data;
   } ixu_wb_lane_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

endpackage

// File: rtl/ixu_ex_wb_pipe_if.sv
// EX->WB bundle bus: EX-side input handshake plus WB-side output handshake.
// The driver of in_* / out_ready uses master; the pipe uses slave.
interface ixu_ex_wb_pipe_if #(
   parameter int LANES = 2,
   parameter int XLEN  = 32,
   parameter int RA_W  = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES-1:0]      in_is_nop;
   logic [LANES*RA_W-1:0] in_rd;
   logic [LANES*XLEN-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [LANES-1:0]      out_is_nop;
   logic [LANES*RA_W-1:0] out_rd;
   logic [LANES*XLEN-1:0] out_data;

   modport master (
      output in_valid, in_is_nop, in_rd, in_data, out_ready,
      input  in_ready, out_valid, out_is_nop, out_rd, out_data
   );

   modport slave (
      input  in_valid, in_is_nop, in_rd, in_data, out_ready,
      output in_ready, out_valid, out_is_nop, out_rd, out_data
   );
endinterface

// File: rtl/ixu_skid_buf.sv
// Two-entry skid buffer over an opaque payload. in_ready and out_valid come
// straight from the state register, so no combinational ready/valid paths.
module ixu_skid_buf
   import ixu_pkg::*;
#(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   skid_state_e  state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         accept, consume;

   assign in_ready  = (state_q != ST_TWO);
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_d  = in_data;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && consume) begin
               main_d = in_data;
            end else if (accept) begin
               skid_d  = in_data;
               state_d = ST_TWO;
            end else if (consume) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (consume) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush only empties; the stale payload is invisible while out_valid is low.
      if (flush) state_d = ST_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= RST_VAL;
         skid_q  <= RST_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/ixu_ex_wb_pipe.sv
// EX->WB stage: packs LANES result slots into one skid-buffered payload,
// folds x0 writes into NOPs on capture, and counts backpressured cycles.
module ixu_ex_wb_pipe
   import ixu_pkg::*;
#(
   parameter int LANES = 2,
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   ixu_ex_wb_pipe_if.slave  bus,
   output logic [CNT_W-1:0] bp_count
);

   localparam int LW = 1 + RA_W + XLEN;
   localparam int PW = LANES * LW;

   typedef struct packed {
      logic            is_nop;
      logic [RA_W-1:0] rd;
      logic [XLEN-1:0] data;
   } lane_t;

   // Reset head: every lane a NOP with zero rd/data.
   function automatic logic [PW-1:0] reset_payload();
      logic [PW-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) r[i*LW + LW - 1] = 1'b1;
      return r;
   endfunction

   localparam logic [PW-1:0] RST_PAY = reset_payload();

   lane_t [LANES-1:0] in_lanes, out_lanes;
   logic  [PW-1:0]    in_pay, out_pay;
   logic              out_valid_w;
   logic [CNT_W-1:0]  bp_count_q, bp_count_d;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign in_lanes[i].is_nop = bus.in_is_nop[i] ||
                                  (bus.in_rd[i*RA_W +: RA_W] == RA_W'(X0_ADDR));
      assign in_lanes[i].rd     = bus.in_rd[i*RA_W +: RA_W];
      assign in_lanes[i].data   = bus.in_data[i*XLEN +: XLEN];

      assign bus.out_is_nop[i]             = out_lanes[i].is_nop;
      assign bus.out_rd[i*RA_W +: RA_W]    = out_lanes[i].rd;
      assign bus.out_data[i*XLEN +: XLEN]  = out_lanes[i].data;
   end

   assign in_pay    = in_lanes;
   assign out_lanes = out_pay;

   ixu_skid_buf #(
      .W       (PW),
      .RST_VAL (RST_PAY)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (in_pay),
      .out_valid (out_valid_w),
      .out_ready (bus.out_ready),
      .out_data  (out_pay)
   );

   assign bus.out_valid = out_valid_w;

   always_comb begin
      bp_count_d = bp_count_q;
      if (out_valid_w && !bus.out_ready && !flush && (bp_count_q != '1))
         bp_count_d = bp_count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) bp_count_q <= '0;
      else     bp_count_q <= bp_count_d;
   end

   assign bp_count = bp_count_q;

endmodule

// File: tb/tb_ixu_ex_wb_pipe.sv
// Randomized bench for ixu_ex_wb_pipe against a queue-based bundle model.
module tb_ixu_ex_wb_pipe;
   localparam int L    = 2;
   localparam int X    = 32;
   localparam int RA   = 5;
   localparam int CW   = 4;
   localparam int PAYW = L + L*RA + L*X;
   localparam int BPMAX = (1 << CW) - 1;

   typedef struct {
      logic [L-1:0]    nop;
      logic [L*RA-1:0] rd;
      logic [L*X-1:0]  data;
   } bundle_t;

   logic          clk = 1'b0;
   logic          rst, flush;
   logic [CW-1:0] bp_count;
   int            n_chk = 0, n_pass = 0;
   bundle_t       mq[$];
   int            mbp = 0;

   ixu_ex_wb_pipe_if #(.LANES(L), .XLEN(X), .RA_W(RA)) bus ();

   ixu_ex_wb_pipe #(.LANES(L), .XLEN(X), .RA_W(RA), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .bus      (bus),
      .bp_count (bp_count)
   );

   always #5 clk = ~clk;

   function automatic bundle_t mk(logic [L-1:0] nop, logic [L*RA-1:0] rd, logic [L*X-1:0] data);
      bundle_t b;
      b.nop = nop;
      for (int i = 0; i < L; i++) if (rd[i*RA +: RA] == 0) b.nop[i] = 1'b1;
      b.rd = rd;
      b.data = data;
      return b;
   endfunction

   function automatic logic [CW+1:0] exp_ctl();
      return {mq.size() != 0, mq.size() < 2, CW'(mbp)};
   endfunction

   function automatic logic [PAYW-1:0] exp_pay();
      if (mq.size() == 0) return '0;
      return {mq[0].nop, mq[0].rd, mq[0].data};
   endfunction

   function automatic logic [PAYW-1:0] dut_pay();
      return {bus.out_is_nop, bus.out_rd, bus.out_data};
   endfunction

   task automatic set_in(bit v, bit ordy, bit fl, logic [L-1:0] nop,
                         logic [L*RA-1:0] rd, logic [L*X-1:0] data);
      bus.in_valid  = v;
      bus.out_ready = ordy;
      flush         = fl;
      bus.in_is_nop = nop;
      bus.in_rd     = rd;
      bus.in_data   = data;
   endtask

   task automatic set_rand(bit v, bit ordy, bit fl);
      logic [L*RA-1:0] rd;
      logic [L*X-1:0]  d;
      for (int i = 0; i < L; i++) begin
         rd[i*RA +: RA] = RA'($urandom_range(0, 31));
         d[i*X +: X]    = $urandom;
      end
      set_in(v, ordy, fl, L'($urandom_range(0, 3) == 0 ? 1 : 0), rd, d);
   endtask

   // Advance one clock; the model follows the bundle-queue rules.
   task automatic cycle();
      int n;
      bundle_t b;
      @(posedge clk);
      n = mq.size();
      if (rst) begin
         mq.delete();
         mbp = 0;
      end else if (flush) begin
         mq.delete();
      end else begin
         if (n > 0 && !bus.out_ready && mbp < BPMAX) mbp++;
         if (n > 0 && bus.out_ready) b = mq.pop_front();
         if (bus.in_valid && n < 2) mq.push_back(mk(bus.in_is_nop, bus.in_rd, bus.in_data));
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(0, 0, 0, '0, '0, '0);
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if ({bus.out_valid, bus.in_ready, bus.out_is_nop, bus.out_rd, bus.out_data, bp_count} !==
          {1'b0, 1'b1, {L{1'b1}}, {(L*RA){1'b0}}, {(L*X){1'b0}}, {CW{1'b0}}})
         $display("FAIL reset got v=%b r=%b nop=%b rd=%h d=%h bp=%0d want v=0 r=1 nop=11 rd=0 d=0 bp=0",
                  bus.out_valid, bus.in_ready, bus.out_is_nop, bus.out_rd, bus.out_data, bp_count);
      else n_pass++;
   endtask

   task automatic test_stream();
      logic [7:0] tag;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         tag = 8'(8'h11 * (k + 1));
         if (k < 4) set_in(1, 1, 0, '0, {RA'(4), RA'(3)}, {X'($urandom) | X'(tag), X'(tag)});
         else       set_in(0, 1, 0, '0, '0, '0);
         cycle();
         n_chk++;
         if ({bus.out_valid, bus.in_ready, bp_count} !== exp_ctl() || (k < 4 && !bus.out_valid))
            $display("FAIL stream_ctl k=%0d got %b want %b", k, {bus.out_valid, bus.in_ready, bp_count}, exp_ctl());
         else n_pass++;
         if (k < 4) begin
            n_chk++;
            if (dut_pay() !== exp_pay() || bus.out_data[7:0] !== tag)
               $display("FAIL stream_pay k=%0d got %h want %h", k, dut_pay(), exp_pay());
            else n_pass++;
         end
      end
   endtask

   task automatic test_backpressure();
      logic [PAYW-1:0] snap;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_rand(1, 0, 0);
         cycle();
         if (k == 0) snap = dut_pay();
         n_chk++;
         if ({bus.out_valid, bus.in_ready, bp_count} !== exp_ctl() || dut_pay() !== snap)
            $display("FAIL bp_hold k=%0d got %b/%h want %b/%h", k,
                     {bus.out_valid, bus.in_ready, bp_count}, dut_pay(), exp_ctl(), snap);
         else n_pass++;
      end
      n_chk++;
      if (bp_count !== CW'(3) || bus.in_ready !== 1'b0)
         $display("FAIL bp_count3 got bp=%0d r=%b want bp=3 r=0", bp_count, bus.in_ready);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         set_in(0, 1, 0, '0, '0, '0);
         cycle();
         n_chk++;
         if ({bus.out_valid, bus.in_ready, bp_count} !== exp_ctl() ||
             (bus.out_valid && dut_pay() !== exp_pay()))
            $display("FAIL bp_drain k=%0d got %b/%h want %b/%h", k,
                     {bus.out_valid, bus.in_ready, bp_count}, dut_pay(), exp_ctl(), exp_pay());
         else n_pass++;
      end
   endtask

   task automatic test_x0();
      do_reset();
      set_in(1, 1, 0, 2'b00, {RA'(0), RA'(7)}, {X'(32'hDEAD), X'($urandom)});
      cycle();
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_is_nop !== 2'b10 || bus.out_rd[RA +: RA] !== '0 ||
          bus.out_data[X +: X] !== 32'hDEAD || bus.out_rd[RA-1:0] !== RA'(7))
         $display("FAIL x0_suppress got v=%b nop=%b rd=%h d1=%h want v=1 nop=10 rd1=0 rd0=7 d1=dead",
                  bus.out_valid, bus.out_is_nop, bus.out_rd, bus.out_data[X +: X]);
      else n_pass++;
   endtask

   task automatic test_flush();
      do_reset();
      set_rand(1, 0, 0); cycle();
      set_rand(1, 0, 0); cycle();
      set_in(1, 1, 1, '0, {RA'(9), RA'(9)}, {X'(32'hBAD0BAD0), X'(32'hBAD0BAD0)});
      cycle();
      n_chk++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || {bus.out_valid, bus.in_ready, bp_count} !== exp_ctl())
         $display("FAIL flush got v=%b r=%b bp=%0d want v=0 r=1 bp=%0d", bus.out_valid, bus.in_ready, bp_count, mbp);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         set_in(0, 1, 0, '0, '0, '0);
         cycle();
         n_chk++;
         if (bus.out_valid !== 1'b0)
            $display("FAIL flush_leak k=%0d got v=%b want v=0", k, bus.out_valid);
         else n_pass++;
      end
   endtask

   task automatic test_saturate();
      do_reset();
      set_rand(1, 0, 0);
      cycle();
      for (int k = 0; k < 20; k++) begin
         set_in(0, 0, 0, '0, '0, '0);
         cycle();
      end
      n_chk++;
      if (bp_count !== CW'(BPMAX) || bus.out_valid !== 1'b1)
         $display("FAIL bp_saturate got bp=%0d v=%b want bp=%0d v=1", bp_count, bus.out_valid, BPMAX);
      else n_pass++;
   endtask

   task automatic test_rst_mid();
      do_reset();
      set_rand(1, 0, 0); cycle();
      set_rand(1, 0, 0); cycle();
      rst = 1'b1;
      set_rand(1, 1, 1);
      cycle();
      rst = 1'b0;
      n_chk++;
      if ({bus.out_valid, bus.in_ready, bus.out_is_nop, bus.out_rd, bus.out_data, bp_count} !==
          {1'b0, 1'b1, {L{1'b1}}, {(L*RA){1'b0}}, {(L*X){1'b0}}, {CW{1'b0}}})
         $display("FAIL rst_mid got v=%b r=%b nop=%b rd=%h d=%h bp=%0d want reset values",
                  bus.out_valid, bus.in_ready, bus.out_is_nop, bus.out_rd, bus.out_data, bp_count);
      else n_pass++;
      set_rand(1, 1, 0);
      cycle();
      n_chk++;
      if (bus.out_valid !== 1'b1 || dut_pay() !== exp_pay())
         $display("FAIL rst_mid_first got v=%b %h want v=1 %h", bus.out_valid, dut_pay(), exp_pay());
      else n_pass++;
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         set_rand($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
         cycle();
         n_chk++;
         if ({bus.out_valid, bus.in_ready, bp_count} !== exp_ctl() ||
             (bus.out_valid && dut_pay() !== exp_pay())) begin
            if (bad < 5)
               $display("FAIL random k=%0d got %b/%h want %b/%h", k,
                        {bus.out_valid, bus.in_ready, bp_count}, dut_pay(), exp_ctl(), exp_pay());
            bad++;
         end else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, '0, '0, '0);
      test_reset();
      test_stream();
      test_backpressure();
      test_x0();
      test_flush();
      test_saturate();
      test_rst_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
